vinsn_scoreboard: RTL and testbench

Hazard-tracking issue gate between `vinsn_decoder` and `vinsn_launcher`. Records every accepted vector instruction's destination register by `insn_id`, stalls a new instruction whose sources or destination overlap an in-flight write (RAW/WAW), and releases entries when the commit controller reports completion. Its output is registered: one-entry skid-free pipe stage feeding the launcher's issue port.

---
 rtl/core_pkg.sv | 29 ++
 rtl/sb_hazard_check.sv | 26 ++
 rtl/vinsn_scoreboard.sv | 93 +++++++++
 tb/tb_vinsn_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: vector register and instruction-ID widths, and the decoded
// issue request passed from the decoder through the scoreboard to the launcher.
package core_pkg;

    localparam int unsigned InsnIDNum = 8;
    localparam int unsigned NrVReg    = 32;

    typedef logic [$clog2(InsnIDNum)-1:0]   insn_id_t;
    typedef logic [$clog2(NrVReg)-1:0]      vreg_t;
    typedef logic [$clog2(InsnIDNum+1)-1:0] sb_cnt_t;

    typedef enum logic [1:0] {
        OpAlu,
        OpMul,
        OpLoad,
        OpStore
    } vop_e;

    // use_vs[0] qualifies vs1, use_vs[1] qualifies vs2
    typedef struct packed {
        vop_e       op;
        insn_id_t   insn_id;
        logic [1:0] use_vs;
        vreg_t      vs2;
        vreg_t      vs1;
        vreg_t      vd;
    } issue_req_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW detector: flags a request whose destination or qualified
// sources match the destination of any busy scoreboard entry.
module sb_hazard_check
    import core_pkg::*;
#(
    parameter int unsigned NumEntries = core_pkg::InsnIDNum
) (
    input  logic [NumEntries-1:0]         busy_q,
    input  vreg_t [NumEntries-1:0]        vd_q,
    input  issue_req_t                    req,
    output logic                          hazard
);

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            if (busy_q[i] &&
                ((vd_q[i] == req.vd) ||
                 (req.use_vs[0] && (vd_q[i] == req.vs1)) ||
                 (req.use_vs[1] && (vd_q[i] == req.vs2)))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vinsn_scoreboard.sv
// Issue gate between decoder and launcher: tracks in-flight destinations per
// instruction ID, stalls hazarding requests, and registers accepted requests.
module vinsn_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NrVReg    = core_pkg::NrVReg,
    parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               dec_req_valid_i,
    output logic                               dec_req_ready_o,
    input  issue_req_t                         dec_req_i,
    output logic                               launch_req_valid_o,
    input  logic                               launch_req_ready_i,
    output issue_req_t                         launch_req_o,
    input  logic                               done_i,
    input  insn_id_t                           done_insn_id_i,
    output logic [$clog2(InsnIDNum+1)-1:0]     inflight_cnt_o,
    output logic                               idle_o
);

    localparam int unsigned VRegW = $clog2(NrVReg);
    localparam int unsigned CntW  = $clog2(InsnIDNum+1);

    logic [InsnIDNum-1:0]            busy_q, busy_d;
    logic [InsnIDNum-1:0][VRegW-1:0] vd_q;
    logic [CntW-1:0]                 cnt_q;
    logic                            launch_valid_q;
    issue_req_t                      launch_req_q;

    logic hazard, full, accept, retire;

    sb_hazard_check #(
        .NumEntries (InsnIDNum)
    ) i_hazard (
        .busy_q (busy_q),
        .vd_q   (vd_q),
        .req    (dec_req_i),
        .hazard (hazard)
    );

    assign full            = (cnt_q == CntW'(InsnIDNum));
    assign dec_req_ready_o = !hazard && !full && (!launch_valid_q || launch_req_ready_i);
    assign accept          = dec_req_valid_i && dec_req_ready_o;
    // A retire of an entry that is already clear is ignored entirely.
    assign retire          = done_i && busy_q[done_insn_id_i];

    // Accept is applied after retire so a same-ID collision leaves the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (retire) busy_d[done_insn_id_i] = 1'b0;
        if (accept) busy_d[dec_req_i.insn_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept && !retire)      cnt_q <= cnt_q + 1'b1;
            else if (retire && !accept) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) vd_q[dec_req_i.insn_id] <= dec_req_i.vd;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 launch_valid_q <= 1'b0;
        else if (accept)             launch_valid_q <= 1'b1;
        else if (launch_req_ready_i) launch_valid_q <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (accept) launch_req_q <= dec_req_i;
    end

    assign launch_req_valid_o = launch_valid_q;
    assign launch_req_o       = launch_req_q;
    assign inflight_cnt_o     = cnt_q;
    assign idle_o             = (cnt_q == '0) && !launch_valid_q;

    a_retire_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_i |-> busy_q[done_insn_id_i]);

    a_unique_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (!busy_q[dec_req_i.insn_id] ||
                    (done_i && (done_insn_id_i == dec_req_i.insn_id))));

endmodule

// File: tb/tb_vinsn_scoreboard.sv
// Directed and randomized bench for vinsn_scoreboard against an entry-set
// reference model of the hazard, occupancy and output-stage rules.
module tb_vinsn_scoreboard;
    import core_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       dec_req_valid_i;
    logic       dec_req_ready_o;
    issue_req_t dec_req_i;
    logic       launch_req_valid_o;
    logic       launch_req_ready_i;
    issue_req_t launch_req_o;
    logic       done_i;
    insn_id_t   done_insn_id_i;
    sb_cnt_t    inflight_cnt_o;
    logic       idle_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    vinsn_scoreboard dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .dec_req_valid_i    (dec_req_valid_i),
        .dec_req_ready_o    (dec_req_ready_o),
        .dec_req_i          (dec_req_i),
        .launch_req_valid_o (launch_req_valid_o),
        .launch_req_ready_i (launch_req_ready_i),
        .launch_req_o       (launch_req_o),
        .done_i             (done_i),
        .done_insn_id_i     (done_insn_id_i),
        .inflight_cnt_o     (inflight_cnt_o),
        .idle_o             (idle_o)
    );

    // Reference model: set of in-flight IDs with their destinations, plus output stage.
    logic       m_busy [InsnIDNum];
    vreg_t      m_vd   [InsnIDNum];
    logic       m_oval;
    issue_req_t m_oreq;
    logic       last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < InsnIDNum; i++) begin
            m_busy[i] = 1'b0;
            m_vd[i]   = '0;
        end
        m_oval   = 1'b0;
        m_oreq   = '0;
        last_acc = 1'b0;
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < InsnIDNum; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic m_hazard(issue_req_t r);
        for (int i = 0; i < InsnIDNum; i++) begin
            if (m_busy[i] && (m_vd[i] == r.vd ||
                              (r.use_vs[0] && m_vd[i] == r.vs1) ||
                              (r.use_vs[1] && m_vd[i] == r.vs2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_ready();
        return !m_hazard(dec_req_i) && (m_count() < InsnIDNum) &&
               (!m_oval || launch_req_ready_i);
    endfunction

    task automatic clear_inputs();
        dec_req_valid_i    = 1'b0;
        dec_req_i          = '0;
        done_i             = 1'b0;
        done_insn_id_i     = '0;
        launch_req_ready_i = 1'b1;
    endtask

    task automatic req(input int id, input int vd, input int vs1, input int vs2,
                       input logic [1:0] use_vs);
        issue_req_t r;
        r.op      = OpAlu;
        r.insn_id = insn_id_t'(id);
        r.vd      = vreg_t'(vd);
        r.vs1     = vreg_t'(vs1);
        r.vs2     = vreg_t'(vs2);
        r.use_vs  = use_vs;
        dec_req_i       = r;
        dec_req_valid_i = 1'b1;
    endtask

    // Called shortly after a rising edge with inputs set; returns 1 ns after the next edge.
    task automatic cycle();
        logic       exp_rdy;
        issue_req_t r;
        #3;
        exp_rdy = m_ready();
        chk("dec_req_ready", 64'(dec_req_ready_o), 64'(exp_rdy));
        r        = dec_req_i;
        last_acc = dec_req_valid_i && exp_rdy;
        if (done_i && m_busy[done_insn_id_i]) m_busy[done_insn_id_i] = 1'b0;
        if (last_acc) begin
            m_busy[r.insn_id] = 1'b1;
            m_vd[r.insn_id]   = r.vd;
            m_oval            = 1'b1;
            m_oreq            = r;
        end else if (m_oval && launch_req_ready_i) begin
            m_oval = 1'b0;
        end
        @(posedge clk_i);
        #1;
        chk("launch_valid", 64'(launch_req_valid_o), 64'(m_oval));
        chk("inflight_cnt", 64'(inflight_cnt_o), 64'(m_count()));
        chk("idle", 64'(idle_o), 64'((m_count() == 0) && !m_oval));
        if (m_oval) chk("launch_req", 64'(launch_req_o), 64'(m_oreq));
    endtask

    task automatic retire(input int id);
        dec_req_valid_i = 1'b0;
        done_i          = 1'b1;
        done_insn_id_i  = insn_id_t'(id);
        cycle();
        done_i = 1'b0;
    endtask

    initial begin
        int         busy_ids [$];
        int         free_ids [$];
        logic       pend;
        issue_req_t r;

        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(launch_req_valid_o), 64'd0);
        chk("rst_cnt", 64'(inflight_cnt_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_ready", 64'(dec_req_ready_o), 64'd1);
        rst_ni = 1'b1;

        // RAW on vs2, released one cycle after the retire
        req(0, 4, 0, 0, 2'b00); cycle();
        chk("raw_launch0", 64'(launch_req_valid_o), 64'd1);
        req(1, 5, 0, 4, 2'b10);
        repeat (3) begin
            cycle();
            chk("raw_stall", 64'(dec_req_ready_o), 64'd0);
        end
        done_i = 1'b1; done_insn_id_i = 0;
        #1 chk("raw_no_bypass", 64'(dec_req_ready_o), 64'd0);
        cycle();
        done_i = 1'b0;
        #1 chk("raw_release", 64'(dec_req_ready_o), 64'd1);
        cycle();
        dec_req_valid_i = 1'b0;
        chk("raw_launch1_valid", 64'(launch_req_valid_o), 64'd1);
        chk("raw_launch1_id", 64'(launch_req_o.insn_id), 64'd1);
        retire(1);

        // unqualified vs1 does not stall
        req(0, 4, 0, 0, 2'b00); cycle();
        req(1, 6, 4, 0, 2'b10);
        #1 chk("unused_vs_ready", 64'(dec_req_ready_o), 64'd1);
        cycle();
        dec_req_valid_i = 1'b0;
        chk("unused_vs_launch", 64'(launch_req_o.insn_id), 64'd1);
        retire(0); retire(1);

        // WAW
        req(0, 8, 1, 2, 2'b11); cycle();
        req(1, 8, 3, 3, 2'b00);
        repeat (2) begin
            cycle();
            chk("waw_stall", 64'(dec_req_ready_o), 64'd0);
        end
        done_i = 1'b1; done_insn_id_i = 0; cycle();
        done_i = 1'b0; cycle();
        dec_req_valid_i = 1'b0;
        chk("waw_launch_id", 64'(launch_req_o.insn_id), 64'd1);
        chk("waw_launch_vd", 64'(launch_req_o.vd), 64'd8);
        retire(1);

        // full table
        for (int i = 0; i < InsnIDNum; i++) begin
            req(i, 10 + i, 0, 0, 2'b00); cycle();
        end
        dec_req_valid_i = 1'b0;
        #1;
        chk("full_cnt", 64'(inflight_cnt_o), 64'(InsnIDNum));
        chk("full_ready_low", 64'(dec_req_ready_o), 64'd0);
        req(3, 20, 0, 0, 2'b00); done_i = 1'b1; done_insn_id_i = 3;
        #1 chk("full_retire_same_cycle", 64'(dec_req_ready_o), 64'd0);
        cycle();
        done_i = 1'b0;
        #1 chk("full_next_cycle", 64'(dec_req_ready_o), 64'd1);
        cycle();
        dec_req_valid_i = 1'b0;
        chk("full_cnt_after", 64'(inflight_cnt_o), 64'(InsnIDNum));
        for (int i = 0; i < InsnIDNum; i++) retire(i);

        // same-cycle retire and accept on one ID: accept wins
        req(2, 9, 0, 0, 2'b00); cycle();
        req(2, 11, 0, 0, 2'b00); done_i = 1'b1; done_insn_id_i = 2;
        cycle();
        done_i = 1'b0; dec_req_valid_i = 1'b0;
        chk("same_id_cnt", 64'(inflight_cnt_o), 64'd1);
        chk("same_id_vd", 64'(launch_req_o.vd), 64'd11);
        req(5, 0, 11, 0, 2'b01);
        #1 chk("same_id_new_vd_blocks", 64'(dec_req_ready_o), 64'd0);
        dec_req_valid_i = 1'b0;
        retire(2);

        // launcher backpressure
        launch_req_ready_i = 1'b0;
        req(0, 1, 0, 0, 2'b00); cycle();
        req(1, 2, 0, 0, 2'b00);
        repeat (3) begin
            cycle();
            chk("bp_hold_id", 64'(launch_req_o.insn_id), 64'd0);
            chk("bp_ready_low", 64'(dec_req_ready_o), 64'd0);
        end
        launch_req_ready_i = 1'b1;
        #1 chk("bp_drain_accept", 64'(dec_req_ready_o), 64'd1);
        cycle();
        chk("bp_launch1", 64'(launch_req_o.insn_id), 64'd1);
        req(2, 3, 0, 0, 2'b00); cycle();
        chk("bp_launch2", 64'(launch_req_o.insn_id), 64'd2);
        req(3, 4, 0, 0, 2'b00); cycle();
        chk("bp_launch3", 64'(launch_req_o.insn_id), 64'd3);
        dec_req_valid_i = 1'b0; cycle();
        chk("bp_drained", 64'(launch_req_valid_o), 64'd0);
        for (int i = 0; i < 4; i++) retire(i);

        // randomized traffic with narrow register range to provoke hazards
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            launch_req_ready_i = ($urandom_range(0, 3) != 0);
            done_i = 1'b0;
            busy_ids.delete();
            free_ids.delete();
            for (int i = 0; i < InsnIDNum; i++) begin
                if (m_busy[i]) busy_ids.push_back(i);
                else           free_ids.push_back(i);
            end
            if (busy_ids.size() > 0 && $urandom_range(0, 2) == 0) begin
                done_i         = 1'b1;
                done_insn_id_i = insn_id_t'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
            end
            if (!pend) begin
                if (free_ids.size() > 0 && $urandom_range(0, 3) != 0) begin
                    r.op      = vop_e'($urandom_range(0, 3));
                    r.insn_id = insn_id_t'(free_ids[$urandom_range(0, free_ids.size() - 1)]);
                    r.vd      = vreg_t'($urandom_range(0, 7));
                    r.vs1     = vreg_t'($urandom_range(0, 7));
                    r.vs2     = vreg_t'($urandom_range(0, 7));
                    r.use_vs  = 2'($urandom_range(0, 3));
                    dec_req_i       = r;
                    dec_req_valid_i = 1'b1;
                    pend            = 1'b1;
                end else begin
                    dec_req_valid_i = 1'b0;
                end
            end
            cycle();
            if (last_acc) begin
                pend            = 1'b0;
                dec_req_valid_i = 1'b0;
            end
        end

        // asynchronous reset mid-operation
        done_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(launch_req_valid_o), 64'd0);
        chk("mid_rst_cnt", 64'(inflight_cnt_o), 64'd0);
        chk("mid_rst_idle", 64'(idle_o), 64'd1);
        chk("mid_rst_ready", 64'(dec_req_ready_o), 64'd1);
        clear_inputs();
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        req(0, 1, 0, 0, 2'b00); cycle();
        dec_req_valid_i = 1'b0;
        chk("post_rst_launch", 64'(launch_req_valid_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
